jump_redirect_ctrl: RTL

//  Sequences MIPS J/JAL/JR/JALR control transfer between decode and fetch.

---
 rtl/mips_jump_pkg.sv | 36 +++
 rtl/jump_target_calc.sv | 36 +++
 rtl/jump_redirect_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_jump_pkg.sv
// mips_jump_pkg: shared encodings and default widths for the jump redirect controller.
//   jmp_kind_e : decoded jump kind (J / JAL / JR / JALR)
//   state_e    : controller FSM states (IDLE / SLOT / ISSUE)
//   DEF_*      : default PC width, instruction index width and JAL link register
package mips_jump_pkg;

   localparam int unsigned DEF_ADDR_W   = 32;
   localparam int unsigned DEF_IDX_W    = 26;
   localparam int unsigned DEF_LINK_REG = 31;
   localparam int unsigned REG_ADDR_W   = 5;

   typedef enum logic [1:0] {
      KIND_J    = 2'b00,
      KIND_JAL  = 2'b01,
      KIND_JR   = 2'b10,
      KIND_JALR = 2'b11
   } jmp_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SLOT  = 2'b01,
      ST_ISSUE = 2'b10
   } state_e;

   // JR/JALR take their target from a register rather than the index field.
   function automatic logic is_reg_jump(input jmp_kind_e kind);
      return (kind == KIND_JR) || (kind == KIND_JALR);
   endfunction

   // JAL always links; JALR links unless its destination is r0.
   function automatic logic needs_link(input jmp_kind_e kind,
                                       input logic [REG_ADDR_W-1:0] rd);
      return (kind == KIND_JAL) || ((kind == KIND_JALR) && (rd != '0));
   endfunction

endpackage

// File: rtl/jump_target_calc.sv
// jump_target_calc: combinational jump target former.
//   kind       in  : decoded jump kind
//   index      in  : instr_index field (J/JAL)
//   reg_val    in  : rs value (JR/JALR)
//   pc_plus4   in  : PC of the jump + 4, supplies the upper segment for J/JAL
//   target     out : new PC
//   misaligned out : register target with non-zero low two bits
module jump_target_calc
   import mips_jump_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned IDX_W  = DEF_IDX_W
) (
   input  jmp_kind_e          kind,
   input  logic [IDX_W-1:0]   index,
   input  logic [ADDR_W-1:0]  reg_val,
   input  logic [ADDR_W-1:0]  pc_plus4,
   output logic [ADDR_W-1:0]  target,
   output logic               misaligned
);

   // Upper PC bits kept from pc_plus4 for region-relative jumps (4 bits at 32/26).
   localparam int unsigned SEG_W = ADDR_W - IDX_W - 2;

   always_comb begin
      target     = '0;
      misaligned = 1'b0;
      if (is_reg_jump(kind)) begin
         target     = reg_val;
         misaligned = |reg_val[1:0];
      end else begin
         target = {pc_plus4[ADDR_W-1 -: SEG_W], index, 2'b00};
      end
   end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl: sequences J/JAL/JR/JALR control transfer between decode and fetch.
// Accepts one decoded jump at a time, forms its target, optionally waits for the
// delay-slot fetch, then issues a valid/ready redirect and a one-cycle link write.
// Build option: DELAY_SLOT_EN -- MIPS delay-slot semantics (SLOT state, no flush,
// link_data = pc_plus4 + 4). Undefined: redirect immediately with a flush pulse,
// link_data = pc_plus4.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   jmp_valid/jmp_ready             : decode handshake (ready only in IDLE)
//   jmp_kind/jmp_index/jmp_reg/jmp_rd/pc_plus4 : decoded jump payload
//   slot_fetched                    : fetch accepted the delay-slot instruction
//   redir_valid/redir_ready/redir_target : redirect handshake to fetch
//   flush                           : one-cycle wrong-path kill
//   link_we/link_addr/link_data     : register-file link write
//   misalign_err                    : one-cycle pulse on misaligned register target
//   busy                            : controller not idle
module jump_redirect_ctrl
   import mips_jump_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned IDX_W    = DEF_IDX_W,
   parameter int unsigned LINK_REG = DEF_LINK_REG
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  jmp_valid,
   output logic                  jmp_ready,
   input  logic [1:0]            jmp_kind,
   input  logic [IDX_W-1:0]      jmp_index,
   input  logic [ADDR_W-1:0]     jmp_reg,
   input  logic [REG_ADDR_W-1:0] jmp_rd,
   input  logic [ADDR_W-1:0]     pc_plus4,
   input  logic                  slot_fetched,
   output logic                  redir_valid,
   input  logic                  redir_ready,
   output logic [ADDR_W-1:0]     redir_target,
   output logic                  flush,
   output logic                  link_we,
   output logic [REG_ADDR_W-1:0] link_addr,
   output logic [ADDR_W-1:0]     link_data,
   output logic                  misalign_err,
   output logic                  busy
);

   state_e             state;
   jmp_kind_e          kind;
   logic [ADDR_W-1:0]  calc_target;
   logic               calc_misaligned;
   logic [ADDR_W-1:0]  link_value;
   logic               accept;

   assign kind   = jmp_kind_e'(jmp_kind);
   assign accept = jmp_valid && jmp_ready;

`ifdef DELAY_SLOT_EN
   // Return past the delay slot.
   assign link_value = pc_plus4 + ADDR_W'(4);
`else
   assign link_value = pc_plus4;
   logic unused_slot_fetched;
   assign unused_slot_fetched = slot_fetched;
`endif

   jump_target_calc #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
   ) u_target_calc (
      .kind       (kind),
      .index      (jmp_index),
      .reg_val    (jmp_reg),
      .pc_plus4   (pc_plus4),
      .target     (calc_target),
      .misaligned (calc_misaligned)
   );

   // Control FSM with registered handshake and pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         jmp_ready    <= 1'b1;
         redir_valid  <= 1'b0;
         redir_target <= '0;
         flush        <= 1'b0;
         link_we      <= 1'b0;
         link_addr    <= '0;
         link_data    <= '0;
         misalign_err <= 1'b0;
         busy         <= 1'b0;
      end else begin
         flush        <= 1'b0;
         link_we      <= 1'b0;
         misalign_err <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  // Payload captured here is held untouched until the next accept,
                  // which keeps redir_target stable through any redirect stall.
                  redir_target <= calc_target;
                  link_data    <= link_value;
                  unique case (kind)
                     KIND_JAL:  link_addr <= REG_ADDR_W'(LINK_REG);
                     KIND_JALR: link_addr <= jmp_rd;
                     default:   link_addr <= '0;
                  endcase
                  // Ready drops for one cycle even on a rejected jump so the
                  // accept cycle is never followed by another accept.
                  jmp_ready <= 1'b0;
                  if (calc_misaligned) begin
                     misalign_err <= 1'b1;
                  end else begin
                     link_we <= needs_link(kind, jmp_rd);
                     busy    <= 1'b1;
`ifdef DELAY_SLOT_EN
                     state   <= ST_SLOT;
`else
                     state       <= ST_ISSUE;
                     redir_valid <= 1'b1;
                     flush       <= 1'b1;
`endif
                  end
               end else begin
                  jmp_ready <= 1'b1;
               end
            end
`ifdef DELAY_SLOT_EN
            ST_SLOT: begin
               if (slot_fetched) begin
                  state       <= ST_ISSUE;
                  redir_valid <= 1'b1;
               end
            end
`endif
            ST_ISSUE: begin
               if (redir_ready) begin
                  state       <= ST_IDLE;
                  redir_valid <= 1'b0;
                  busy        <= 1'b0;
                  jmp_ready   <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               redir_valid <= 1'b0;
               busy        <= 1'b0;
               jmp_ready   <= 1'b1;
            end
         endcase
      end
   end

endmodule
